// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM states for the console writer.
// CONSOLE_FF_CLEAR_EN adds the CLEAR_SCREEN state for form feed.
package console_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 60;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR_LINE
`ifdef CONSOLE_FF_CLEAR_EN
        ,
        CLEAR_SCREEN
`endif
    } state_t;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/tile_addr.sv
// Combinational (x,y) -> linear tile address, built from shifted copies
// of y for each set bit of COLS so no multiplier is inferred.
module tile_addr
    import console_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ADDR_W = 13
) (
    input  logic [6:0]        x,
    input  logic [5:0]        y,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        addr = ADDR_W'(x);
        // For 80 this reduces to (y<<6) + (y<<4) + x
        for (int i = 0; i < 32; i++) begin
            if (COLS[i]) begin
                addr = addr + (ADDR_W'(y) << i);
            end
        end
    end

endmodule

// File: rtl/console_writer.sv
// Byte-stream text writer for the tile background RAM with cursor control.
// Define CONSOLE_FF_CLEAR_EN to make 0x0C clear the whole screen.
module console_writer
    import console_pkg::*;
#(
    parameter int                COLS   = COLS_DEF,
    parameter int                ROWS   = ROWS_DEF,
    parameter int                ADDR_W = 13,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BLANK  = DATA_W'(CH_BLANK)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [6:0]        cursor_x,
    output logic [5:0]        cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
`ifdef CONSOLE_FF_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(COLS * ROWS - 1);
`endif

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] waddr;
    logic [6:0]        wx;
    logic [5:0]        wy;
    logic [5:0]        y_next;
    logic              take;
    logic              print;
    logic              at_eol;

    assign in_ready = (state == IDLE) && !clr;
    assign take     = in_valid && in_ready;
    assign print    = is_print(in_data);
    assign at_eol   = (cursor_x == 7'(COLS - 1));
    assign y_next   = (cursor_y == 6'(ROWS - 1)) ? 6'd0 : cursor_y + 6'd1;

    // One address mapper serves every write source
    always_comb begin
        wx = cursor_x;
        wy = cursor_y;
        if (state == CLEAR_LINE) begin
            wx = cnt[6:0];
        end else if (in_data == CH_BS) begin
            wx = cursor_x - 7'd1;
        end else if (in_data == CH_LF) begin
            wx = 7'd0;
            wy = y_next;
        end
    end

    tile_addr #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_tile_addr (
        .x    (wx),
        .y    (wy),
        .addr (waddr)
    );

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (take) begin
                    if (print)                nxt = at_eol ? CLEAR_LINE : WRITE;
                    else if (in_data == CH_LF) nxt = CLEAR_LINE;
`ifdef CONSOLE_FF_CLEAR_EN
                    else if (in_data == CH_FF) nxt = CLEAR_SCREEN;
`endif
                    else                      nxt = WRITE;
                end
            end
            CLEAR_LINE: if (cnt == LAST_COL) nxt = WRITE;
`ifdef CONSOLE_FF_CLEAR_EN
            CLEAR_SCREEN: if (cnt == LAST_TILE) nxt = WRITE;
`endif
            default: nxt = IDLE;
        endcase
    end

    // A newline issues its first blank write immediately, hence cnt starts at 1
    always_ff @(posedge clk) begin
        if (clr) begin
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
        end else begin
            wea  <= 1'b0;
            busy <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        if (print) begin
                            wea   <= 1'b1;
                            addra <= waddr;
                            dina  <= DATA_W'(in_data);
                            if (at_eol) begin
                                cursor_x <= '0;
                                cursor_y <= y_next;
                                cnt      <= '0;
                            end else begin
                                cursor_x <= cursor_x + 7'd1;
                            end
                        end else if (in_data == CH_LF) begin
                            wea      <= 1'b1;
                            busy     <= 1'b1;
                            addra    <= waddr;
                            dina     <= BLANK;
                            cursor_x <= '0;
                            cursor_y <= y_next;
                            cnt      <= ADDR_W'(1);
                        end else if (in_data == CH_CR) begin
                            cursor_x <= '0;
                        end else if (in_data == CH_BS && cursor_x != 7'd0) begin
                            wea      <= 1'b1;
                            addra    <= waddr;
                            dina     <= BLANK;
                            cursor_x <= cursor_x - 7'd1;
`ifdef CONSOLE_FF_CLEAR_EN
                        end else if (in_data == CH_FF) begin
                            wea      <= 1'b1;
                            busy     <= 1'b1;
                            addra    <= '0;
                            dina     <= BLANK;
                            cursor_x <= '0;
                            cursor_y <= '0;
                            cnt      <= ADDR_W'(1);
`endif
                        end
                    end
                end
                CLEAR_LINE: begin
                    wea   <= 1'b1;
                    busy  <= 1'b1;
                    addra <= waddr;
                    dina  <= BLANK;
                    cnt   <= cnt + 1'b1;
                end
`ifdef CONSOLE_FF_CLEAR_EN
                CLEAR_SCREEN: begin
                    wea   <= 1'b1;
                    busy  <= 1'b1;
                    addra <= cnt;
                    dina  <= BLANK;
                    cnt   <= cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
